// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ctrl_pkg
// Desc     : State codes, opcode/funct constants and control-field codes
//            shared by the multicycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam int c_state_w = 7;
    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_reset      = 7'd0;
    localparam state_t c_st_fetch      = 7'd1;
    localparam state_t c_st_fetch_wait = 7'd2;
    localparam state_t c_st_ir_load    = 7'd3;
    localparam state_t c_st_decode     = 7'd4;
    localparam state_t c_st_exec_r     = 7'd5;
    localparam state_t c_st_wb_r       = 7'd6;
    localparam state_t c_st_exec_i     = 7'd7;
    localparam state_t c_st_wb_i       = 7'd8;
    localparam state_t c_st_addr       = 7'd9;
    localparam state_t c_st_mem_rd     = 7'd10;
    localparam state_t c_st_rd_wait    = 7'd11;
    localparam state_t c_st_mdr_load   = 7'd12;
    localparam state_t c_st_wb_lw      = 7'd13;
    localparam state_t c_st_mem_wr     = 7'd14;
    localparam state_t c_st_wr_wait    = 7'd15;
    localparam state_t c_st_branch     = 7'd16;
    localparam state_t c_st_jump       = 7'd17;
    localparam state_t c_st_exception  = 7'd18;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_slt = 6'h2A;

    localparam logic [2:0] c_alu_none = 3'b000;
    localparam logic [2:0] c_alu_add  = 3'b001;
    localparam logic [2:0] c_alu_sub  = 3'b010;
    localparam logic [2:0] c_alu_and  = 3'b011;
    localparam logic [2:0] c_alu_or   = 3'b100;
    localparam logic [2:0] c_alu_slt  = 3'b111;

    localparam logic [1:0] c_srcb_reg     = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh2 = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    typedef struct packed {
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic [1:0] pc_source;
        logic       ab_write;
        logic       alu_out_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    // Returns c_alu_none for any funct the datapath does not implement.
    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        case (funct)
            c_fn_add: return c_alu_add;
            c_fn_sub: return c_alu_sub;
            c_fn_and: return c_alu_and;
            c_fn_or:  return c_alu_or;
            c_fn_slt: return c_alu_slt;
            default:  return c_alu_none;
        endcase
    endfunction

    function automatic logic funct_legal(input logic [5:0] funct);
        return funct_alu_op(funct) != c_alu_none;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_unit_mc_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : wait_counter
// Desc     : Memory-latency down-counter; done while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
module wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CNT_W-1:0] c_load_val = (MEM_WAIT > 0) ? CNT_W'(MEM_WAIT - 1) : '0;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= c_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ctrl_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_unit_mc
// Desc     : Multicycle fetch/decode/execute control FSM for the
//            single-memory MIPS datapath (Moore outputs).
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_unit_mc
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2,
    parameter int STATE_W  = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic               i_or_d,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               pc_write,
    output logic               pc_write_eq,
    output logic               pc_write_ne,
    output logic [1:0]         pc_source,
    output logic               ab_write,
    output logic               alu_out_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               retire,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    localparam bit c_has_wait = (MEM_WAIT > 0);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_rtype_alu_op;
    logic       r_branch_ne;
    logic       w_cnt_load;
    logic       w_cnt_done;
    ctrl_t      w_ctl;

    // Funct and branch sense are captured leaving DECODE so outputs stay a
    // function of registered state only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= c_st_reset;
            r_rtype_alu_op <= c_alu_none;
            r_branch_ne    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == c_st_decode) begin
                r_rtype_alu_op <= funct_alu_op(funct);
                r_branch_ne    <= (opcode == c_op_bne);
            end
        end
    end

    assign w_cnt_load = (r_state == c_st_fetch) || (r_state == c_st_mem_rd) ||
                        (r_state == c_st_mem_wr);

    wait_counter #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait_counter (
        .clock (clock),
        .reset (reset),
        .load  (w_cnt_load),
        .done  (w_cnt_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_reset:      w_next = c_st_fetch;
            c_st_fetch:      w_next = c_has_wait ? c_st_fetch_wait : c_st_ir_load;
            c_st_fetch_wait: w_next = w_cnt_done ? c_st_ir_load : c_st_fetch_wait;
            c_st_ir_load:    w_next = c_st_decode;
            c_st_decode: begin
                case (opcode)
                    c_op_rtype:         w_next = funct_legal(funct) ? c_st_exec_r : c_st_exception;
                    c_op_lw, c_op_sw:   w_next = c_st_addr;
                    c_op_addi:          w_next = c_st_exec_i;
                    c_op_beq, c_op_bne: w_next = c_st_branch;
                    c_op_j:             w_next = c_st_jump;
                    default:            w_next = c_st_exception;
                endcase
            end
            c_st_exec_r:     w_next = c_st_wb_r;
            c_st_wb_r:       w_next = c_st_fetch;
            c_st_exec_i:     w_next = c_st_wb_i;
            c_st_wb_i:       w_next = c_st_fetch;
            c_st_addr:       w_next = (opcode == c_op_lw) ? c_st_mem_rd : c_st_mem_wr;
            c_st_mem_rd:     w_next = c_has_wait ? c_st_rd_wait : c_st_mdr_load;
            c_st_rd_wait:    w_next = w_cnt_done ? c_st_mdr_load : c_st_rd_wait;
            c_st_mdr_load:   w_next = c_st_wb_lw;
            c_st_wb_lw:      w_next = c_st_fetch;
            c_st_mem_wr:     w_next = c_has_wait ? c_st_wr_wait : c_st_fetch;
            c_st_wr_wait:    w_next = w_cnt_done ? c_st_fetch : c_st_wr_wait;
            c_st_branch:     w_next = c_st_fetch;
            c_st_jump:       w_next = c_st_fetch;
            c_st_exception:  w_next = c_st_exception;
            default:         w_next = c_st_exception;
        endcase
    end

    always_comb begin
        w_ctl = '0;
        case (r_state)
            c_st_fetch, c_st_fetch_wait: begin
                w_ctl.alu_src_b = c_srcb_four;
                w_ctl.alu_op    = c_alu_add;
            end
            c_st_ir_load: begin
                w_ctl.alu_src_b = c_srcb_four;
                w_ctl.alu_op    = c_alu_add;
                w_ctl.ir_write  = 1'b1;
                w_ctl.pc_write  = 1'b1;
                w_ctl.pc_source = c_pcsrc_alu;
            end
            c_st_decode: begin
                w_ctl.ab_write      = 1'b1;
                w_ctl.alu_out_write = 1'b1;
                w_ctl.alu_src_b     = c_srcb_imm_sh2;
                w_ctl.alu_op        = c_alu_add;
            end
            c_st_exec_r: begin
                w_ctl.alu_src_a     = 1'b1;
                w_ctl.alu_src_b     = c_srcb_reg;
                w_ctl.alu_op        = r_rtype_alu_op;
                w_ctl.alu_out_write = 1'b1;
            end
            c_st_wb_r: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.reg_dst   = 1'b1;
                w_ctl.retire    = 1'b1;
            end
            c_st_exec_i, c_st_addr: begin
                w_ctl.alu_src_a     = 1'b1;
                w_ctl.alu_src_b     = c_srcb_imm;
                w_ctl.alu_op        = c_alu_add;
                w_ctl.alu_out_write = 1'b1;
            end
            c_st_wb_i: begin
                w_ctl.reg_write = 1'b1;
                w_ctl.retire    = 1'b1;
            end
            c_st_mem_rd, c_st_rd_wait: begin
                w_ctl.i_or_d = 1'b1;
            end
            c_st_mdr_load: begin
                w_ctl.i_or_d    = 1'b1;
                w_ctl.mdr_write = 1'b1;
            end
            c_st_wb_lw: begin
                w_ctl.reg_write  = 1'b1;
                w_ctl.mem_to_reg = 1'b1;
                w_ctl.retire     = 1'b1;
            end
            // A store retires in the last cycle mem_write is held.
            c_st_mem_wr: begin
                w_ctl.i_or_d    = 1'b1;
                w_ctl.mem_write = 1'b1;
                w_ctl.retire    = !c_has_wait;
            end
            c_st_wr_wait: begin
                w_ctl.i_or_d    = 1'b1;
                w_ctl.mem_write = 1'b1;
                w_ctl.retire    = w_cnt_done;
            end
            c_st_branch: begin
                w_ctl.alu_src_a   = 1'b1;
                w_ctl.alu_src_b   = c_srcb_reg;
                w_ctl.alu_op      = c_alu_sub;
                w_ctl.pc_source   = c_pcsrc_aluout;
                w_ctl.pc_write_eq = !r_branch_ne;
                w_ctl.pc_write_ne = r_branch_ne;
                w_ctl.retire      = 1'b1;
            end
            c_st_jump: begin
                w_ctl.pc_write  = 1'b1;
                w_ctl.pc_source = c_pcsrc_jump;
                w_ctl.retire    = 1'b1;
            end
            c_st_exception: begin
                w_ctl.illegal = 1'b1;
            end
            default: w_ctl = '0;
        endcase
    end

    assign i_or_d        = w_ctl.i_or_d;
    assign mem_write     = w_ctl.mem_write;
    assign ir_write      = w_ctl.ir_write;
    assign mdr_write     = w_ctl.mdr_write;
    assign pc_write      = w_ctl.pc_write;
    assign pc_write_eq   = w_ctl.pc_write_eq;
    assign pc_write_ne   = w_ctl.pc_write_ne;
    assign pc_source     = w_ctl.pc_source;
    assign ab_write      = w_ctl.ab_write;
    assign alu_out_write = w_ctl.alu_out_write;
    assign alu_src_a     = w_ctl.alu_src_a;
    assign alu_src_b     = w_ctl.alu_src_b;
    assign alu_op        = w_ctl.alu_op;
    assign reg_write     = w_ctl.reg_write;
    assign reg_dst       = w_ctl.reg_dst;
    assign mem_to_reg    = w_ctl.mem_to_reg;
    assign retire        = w_ctl.retire;
    assign illegal       = w_ctl.illegal;
    assign state         = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_ctrl_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_unit_mc
// Desc     : Random and directed instruction bench for ctrl_unit_mc across
//            MEM_WAIT = 0, 2 and 3, checked against a per-instruction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_unit_mc;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic [1:0] pc_source;
        logic       ab_write;
        logic       alu_out_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       retire;
        logic       illegal;
        logic [6:0] state;
    } obs_t;

    typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_ILL} kind_e;

    logic       clock = 1'b0;
    logic       reset_n [3];
    logic [5:0] opc [3];
    logic [5:0] fnc [3];
    obs_t       obs [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MW = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        logic       w_i_or_d, w_mem_write, w_ir_write, w_mdr_write, w_pc_write;
        logic       w_pc_write_eq, w_pc_write_ne, w_ab_write, w_alu_out_write;
        logic       w_alu_src_a, w_reg_write, w_reg_dst, w_mem_to_reg, w_retire, w_illegal;
        logic [1:0] w_pc_source, w_alu_src_b;
        logic [2:0] w_alu_op;
        logic [6:0] w_state;

        ctrl_unit_mc #(.MEM_WAIT(MW), .STATE_W(7)) u_dut (
            .clock         (clock),
            .reset         (reset_n[g]),
            .opcode        (opc[g]),
            .funct         (fnc[g]),
            .i_or_d        (w_i_or_d),
            .mem_write     (w_mem_write),
            .ir_write      (w_ir_write),
            .mdr_write     (w_mdr_write),
            .pc_write      (w_pc_write),
            .pc_write_eq   (w_pc_write_eq),
            .pc_write_ne   (w_pc_write_ne),
            .pc_source     (w_pc_source),
            .ab_write      (w_ab_write),
            .alu_out_write (w_alu_out_write),
            .alu_src_a     (w_alu_src_a),
            .alu_src_b     (w_alu_src_b),
            .alu_op        (w_alu_op),
            .reg_write     (w_reg_write),
            .reg_dst       (w_reg_dst),
            .mem_to_reg    (w_mem_to_reg),
            .retire        (w_retire),
            .illegal       (w_illegal),
            .state         (w_state)
        );

        assign obs[g] = {w_i_or_d, w_mem_write, w_ir_write, w_mdr_write, w_pc_write,
                         w_pc_write_eq, w_pc_write_ne, w_pc_source, w_ab_write,
                         w_alu_out_write, w_alu_src_a, w_alu_src_b, w_alu_op,
                         w_reg_write, w_reg_dst, w_mem_to_reg, w_retire, w_illegal, w_state};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mw_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                             fn == 6'h25 || fn == 6'h2A) ? K_R : K_ILL;
            6'h08:   return K_ADDI;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h05:   return K_BNE;
            6'h02:   return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int r_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 1;
            6'h22:   return 2;
            6'h24:   return 3;
            6'h25:   return 4;
            default: return 7;
        endcase
    endfunction

    function automatic logic any_we(input obs_t o);
        return o.mem_write | o.ir_write | o.mdr_write | o.pc_write | o.pc_write_eq |
               o.pc_write_ne | o.ab_write | o.alu_out_write | o.reg_write;
    endfunction

    function automatic logic [31:0] no_state(input obs_t o);
        obs_t t;
        t = o;
        t.state = '0;
        return 32'(t);
    endfunction

    // Resets DUT k, runs one instruction from FETCH to the next FETCH (or
    // EXCEPTION) and compares aggregate behaviour with the expected profile.
    task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn);
        int    mw, f, cyc, exp_len;
        int    n_ir, n_pcw, n_ret, n_memw, n_mdr, n_regw, n_iord, n_eq, n_ne;
        int    ir_idx, ret_idx, iord_first, iord_last, ex_alu, br_alu, br_src, pcsrc;
        int    regdst, m2r;
        kind_e kind;
        obs_t  o;

        mw = mw_of(k);
        f = 2 + mw;
        kind = classify(op, fn);
        n_ir = 0; n_pcw = 0; n_ret = 0; n_memw = 0; n_mdr = 0; n_regw = 0;
        n_iord = 0; n_eq = 0; n_ne = 0; ir_idx = -1; ret_idx = -1;
        iord_first = -1; iord_last = -1; ex_alu = -1; br_alu = -1; br_src = -1;
        pcsrc = -1; regdst = -1; m2r = -1;

        opc[k] = op;
        fnc[k] = fn;
        reset_n[k] = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", no_state(obs[k]), 32'd0);
        chk("reset_state", 32'(obs[k].state), 32'(c_st_reset));
        reset_n[k] = 1'b1;
        @(negedge clock);
        chk("fetch_entry", 32'(obs[k].state), 32'(c_st_fetch));

        cyc = 0;
        do begin
            o = obs[k];
            if (o.ir_write) begin n_ir++; ir_idx = cyc; end
            if (o.pc_write) begin n_pcw++; pcsrc = int'(o.pc_source); end
            if (o.retire) begin n_ret++; ret_idx = cyc; end
            if (o.mem_write) n_memw++;
            if (o.mdr_write) n_mdr++;
            if (o.reg_write) begin n_regw++; regdst = int'(o.reg_dst); m2r = int'(o.mem_to_reg); end
            if (o.i_or_d) begin
                n_iord++;
                if (iord_first < 0) iord_first = cyc;
                iord_last = cyc;
            end
            if (o.pc_write_eq || o.pc_write_ne) begin
                n_eq += int'(o.pc_write_eq);
                n_ne += int'(o.pc_write_ne);
                br_alu = int'(o.alu_op);
                br_src = int'(o.pc_source);
            end
            if (o.alu_src_a && o.alu_out_write) ex_alu = int'(o.alu_op);
            cyc++;
            @(negedge clock);
        end while (obs[k].state != c_st_fetch && obs[k].state != c_st_exception && cyc < 64);

        chk("ir_load_index", 32'(ir_idx), 32'(1 + mw));
        chk("ir_write_count", 32'(n_ir), 32'd1);

        if (kind == K_ILL) begin
            chk("illegal_cycles", 32'(cyc), 32'(f + 1));
            chk("illegal_retire", 32'(n_ret), 32'd0);
            for (int i = 0; i < 3; i++) begin
                chk("illegal_state", 32'(obs[k].state), 32'(c_st_exception));
                chk("illegal_flag", 32'(obs[k].illegal), 32'd1);
                chk("illegal_no_we", 32'(any_we(obs[k])), 32'd0);
                @(negedge clock);
            end
        end else begin
            case (kind)
                K_R, K_ADDI: exp_len = f + 3;
                K_LW:        exp_len = f + 5 + mw;
                K_SW:        exp_len = f + 3 + mw;
                default:     exp_len = f + 2;
            endcase
            chk("instr_cycles", 32'(cyc), 32'(exp_len));
            chk("retire_count", 32'(n_ret), 32'd1);
            chk("retire_last_cycle", 32'(ret_idx), 32'(cyc - 1));
            chk("pc_write_count", 32'(n_pcw), (kind == K_J) ? 32'd2 : 32'd1);
            chk("pc_source_last", 32'(pcsrc), (kind == K_J) ? 32'd2 : 32'd0);
            chk("mem_write_cycles", 32'(n_memw), (kind == K_SW) ? 32'(1 + mw) : 32'd0);
            chk("mdr_write_count", 32'(n_mdr), (kind == K_LW) ? 32'd1 : 32'd0);
            chk("reg_write_count", 32'(n_regw),
                (kind == K_R || kind == K_ADDI || kind == K_LW) ? 32'd1 : 32'd0);
            chk("i_or_d_cycles", 32'(n_iord),
                (kind == K_LW) ? 32'(2 + mw) : ((kind == K_SW) ? 32'(1 + mw) : 32'd0));
            if (n_iord > 0)
                chk("i_or_d_contiguous", 32'(iord_last - iord_first + 1), 32'(n_iord));
            if (n_regw > 0) begin
                chk("reg_dst", 32'(regdst), (kind == K_R) ? 32'd1 : 32'd0);
                chk("mem_to_reg", 32'(m2r), (kind == K_LW) ? 32'd1 : 32'd0);
            end
            if (kind == K_R || kind == K_ADDI || kind == K_LW || kind == K_SW)
                chk("exec_alu_op", 32'(ex_alu), (kind == K_R) ? 32'(r_alu(fn)) : 32'd1);
            chk("pc_write_eq_count", 32'(n_eq), (kind == K_BEQ) ? 32'd1 : 32'd0);
            chk("pc_write_ne_count", 32'(n_ne), (kind == K_BNE) ? 32'd1 : 32'd0);
            if (kind == K_BEQ || kind == K_BNE) begin
                chk("branch_pc_source", 32'(br_src), 32'd1);
                chk("branch_alu_op", 32'(br_alu), 32'd2);
            end
        end
    endtask

    // Asynchronous reset landing in the middle of a load's read wait.
    task automatic reset_mid_rd_wait();
        int found;
        opc[1] = 6'h23;
        fnc[1] = 6'h00;
        reset_n[1] = 1'b0;
        repeat (2) @(negedge clock);
        reset_n[1] = 1'b1;
        found = 0;
        for (int i = 0; i < 32 && found == 0; i++) begin
            @(negedge clock);
            if (obs[1].state == c_st_rd_wait) found = 1;
        end
        chk("rd_wait_reached", 32'(found), 32'd1);
        #2 reset_n[1] = 1'b0;
        #1;
        chk("async_reset_state", 32'(obs[1].state), 32'(c_st_reset));
        chk("async_reset_outputs", no_state(obs[1]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("held_reset_no_we", 32'(any_we(obs[1])), 32'd0);
        end
    endtask

    initial begin
        logic [5:0] op_tab [8];
        logic [5:0] fn_tab [5];
        int         k, r;
        logic [5:0] op, fn;

        op_tab = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int i = 0; i < 3; i++) begin
            reset_n[i] = 1'b0;
            opc[i] = 6'h00;
            fnc[i] = 6'h20;
        end

        run_instr(1, 6'h00, 6'h22);
        run_instr(1, 6'h23, 6'h00);
        run_instr(0, 6'h2B, 6'h00);
        run_instr(2, 6'h2B, 6'h00);
        run_instr(1, 6'h05, 6'h00);
        run_instr(1, 6'h02, 6'h00);
        run_instr(1, 6'h3F, 6'h00);
        run_instr(1, 6'h00, 6'h01);
        run_instr(0, 6'h23, 6'h00);
        run_instr(2, 6'h04, 6'h00);
        reset_mid_rd_wait();

        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(0, 2));
            r = int'($urandom_range(0, 9));
            fn = fn_tab[$urandom_range(0, 4)];
            if (r < 8) op = op_tab[r];
            else if (r == 8) op = 6'($urandom_range(0, 63));
            else begin
                op = 6'h00;
                fn = 6'($urandom_range(0, 63));
            end
            run_instr(k, op, fn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
